// File: rtl/y86_seq_controller.sv
// rtl/y86_seq_controller.sv - multi-cycle stage sequencer for the sequential Y86 core
module y86_seq_controller #(
  parameter int ADDR_W = 64,
  parameter logic [ADDR_W-1:0] START_PC = '0,
  parameter int CNT_W = 32,
  parameter int MAX_CYCLES = 0
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic              step_mode,
  input  logic              halt,
  input  logic              inv_instr,
  input  logic              mem_error,
  input  logic              dmem_error,
  input  logic [ADDR_W-1:0] pc_new,
  output logic [ADDR_W-1:0] pc_val,
  output logic [4:0]        stage_en,
  output logic [2:0]        stat,
  output logic              running,
  output logic              done,
  output logic              watchdog_trip,
  output logic [CNT_W-1:0]  cycle_count,
  output logic [CNT_W-1:0]  retired_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXECUTE, S_MEMORY, S_WBPC, S_HALTED
  } state_t;

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(MAX_CYCLES - 1);

  state_t            state, state_nx;
  logic [2:0]        stat_nx;
  logic [ADDR_W-1:0] pc_nx;
  logic              retire, stage_err, trip_nx, in_stage, wd_hit;
  logic [4:0]        stage_en_nx;

  assign in_stage = (state != S_IDLE) && (state != S_HALTED);
  assign wd_hit   = (MAX_CYCLES != 0) && in_stage && (cycle_count == WD_LAST);

  always_comb begin
    state_nx  = state;
    stat_nx   = stat;
    pc_nx     = pc_val;
    retire    = 1'b0;
    stage_err = 1'b0;
    trip_nx   = watchdog_trip;
    case (state)
      S_IDLE:    if (start) state_nx = S_FETCH;
      S_FETCH: begin
        if (mem_error) begin
          stat_nx = STAT_ADR; state_nx = S_HALTED; stage_err = 1'b1;
        end else if (inv_instr) begin
          stat_nx = STAT_INS; state_nx = S_HALTED; stage_err = 1'b1;
        end else if (halt) begin
          stat_nx = STAT_HLT; state_nx = S_HALTED; stage_err = 1'b1; retire = 1'b1;
        end else begin
          state_nx = S_DECODE;
        end
      end
      S_DECODE:  state_nx = S_EXECUTE;
      S_EXECUTE: state_nx = S_MEMORY;
      S_MEMORY: begin
        // A data fault skips WBPC entirely, so neither PC nor retire count moves.
        if (dmem_error) begin
          stat_nx = STAT_ADR; state_nx = S_HALTED; stage_err = 1'b1;
        end else begin
          state_nx = S_WBPC;
        end
      end
      S_WBPC: begin
        pc_nx    = pc_new;
        retire   = 1'b1;
        state_nx = step_mode ? S_IDLE : S_FETCH;
      end
      default:   state_nx = S_HALTED;
    endcase
    if (wd_hit && !stage_err) begin
      state_nx = S_HALTED;
      trip_nx  = 1'b1;
    end
    case (state_nx)
      S_FETCH:   stage_en_nx = 5'b00001;
      S_DECODE:  stage_en_nx = 5'b00010;
      S_EXECUTE: stage_en_nx = 5'b00100;
      S_MEMORY:  stage_en_nx = 5'b01000;
      S_WBPC:    stage_en_nx = 5'b10000;
      default:   stage_en_nx = 5'b00000;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state         <= S_IDLE;
      pc_val        <= START_PC;
      stat          <= STAT_AOK;
      stage_en      <= 5'b0;
      running       <= 1'b0;
      done          <= 1'b0;
      watchdog_trip <= 1'b0;
      cycle_count   <= '0;
      retired_count <= '0;
    end else begin
      state         <= state_nx;
      pc_val        <= pc_nx;
      stat          <= stat_nx;
      stage_en      <= stage_en_nx;
      running       <= |stage_en_nx;
      done          <= (state_nx == S_HALTED);
      watchdog_trip <= trip_nx;
      if (in_stage && cycle_count != CNT_MAX) cycle_count <= cycle_count + 1'b1;
      if (retire && retired_count != CNT_MAX) retired_count <= retired_count + 1'b1;
    end
  end

endmodule
